// File: rtl/seg_pkg.sv
// Shared segment encodings for the multiplexed seven-segment scan driver.
// Segment patterns are active-low, ordered a,b,c,d,e,f,g (bit6..bit0).
package seg_pkg;

    typedef logic [7:0] seg_t;

    localparam seg_t SegBlank = 8'hFF;

    localparam logic [6:0] SegHex0 = 7'b0000001;
    localparam logic [6:0] SegHex1 = 7'b1001111;
    localparam logic [6:0] SegHex2 = 7'b0010010;
    localparam logic [6:0] SegHex3 = 7'b0000110;
    localparam logic [6:0] SegHex4 = 7'b1001100;
    localparam logic [6:0] SegHex5 = 7'b0100100;
    localparam logic [6:0] SegHex6 = 7'b0100000;
    localparam logic [6:0] SegHex7 = 7'b0001111;
    localparam logic [6:0] SegHex8 = 7'b0000000;
    localparam logic [6:0] SegHex9 = 7'b0000100;
    localparam logic [6:0] SegHexA = 7'b0001000;
    localparam logic [6:0] SegHexB = 7'b1100000;
    localparam logic [6:0] SegHexC = 7'b0110001;
    localparam logic [6:0] SegHexD = 7'b1000010;
    localparam logic [6:0] SegHexE = 7'b0110000;
    localparam logic [6:0] SegHexF = 7'b0111000;

    // Appends the active-low decimal point to a glyph.
    function automatic seg_t seg_pack(input logic [6:0] abcdefg, input logic dp_on);
        return {abcdefg, ~dp_on};
    endfunction

endpackage

// File: rtl/seg_hex_decode.sv
// Combinational hex nibble to active-low seven-segment glyph decoder.
module seg_hex_decode
    import seg_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SegHex0;
        unique case (nibble_i)
            4'h0: seg_o = SegHex0;
            4'h1: seg_o = SegHex1;
            4'h2: seg_o = SegHex2;
            4'h3: seg_o = SegHex3;
            4'h4: seg_o = SegHex4;
            4'h5: seg_o = SegHex5;
            4'h6: seg_o = SegHex6;
            4'h7: seg_o = SegHex7;
            4'h8: seg_o = SegHex8;
            4'h9: seg_o = SegHex9;
            4'hA: seg_o = SegHexA;
            4'hB: seg_o = SegHexB;
            4'hC: seg_o = SegHexC;
            4'hD: seg_o = SegHexD;
            4'hE: seg_o = SegHexE;
            4'hF: seg_o = SegHexF;
        endcase
    end

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed seven-segment scan driver with shadowed display data,
// PWM brightness, per-digit blanking and leading-zero suppression.
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = 8,
    parameter int unsigned DIV_WIDTH  = 11
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   blank_mask,
    input  logic                    lz_en,
    input  logic [3:0]              bright,
    output logic [7:0]              seg,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_done
);

    localparam int unsigned    DigW    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [DigW-1:0] LastDig = DigW'(NUM_DIGITS - 1);

    logic [DIV_WIDTH-1:0]    div_cnt_q, div_cnt_d;
    logic [DigW-1:0]         dig_q, dig_d;
    logic                    run_q, run_d;
    logic [4*NUM_DIGITS-1:0] value_q, value_d;
    logic [NUM_DIGITS-1:0]   dp_q, dp_d;
    logic [NUM_DIGITS-1:0]   blank_q, blank_d;
    seg_t                    seg_q, seg_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic                    frame_done_q, frame_done_d;

    logic                    slot_end;
    logic [3:0]              phase;
    logic [3:0]              cur_nib;
    logic                    cur_dp, cur_blank, cur_sup;
    logic                    show;
    logic [6:0]              cur_glyph;
    logic [NUM_DIGITS-1:0]   suppress;

    // Slot/digit sequencing and shadow capture.
    always_comb begin
        slot_end  = &div_cnt_q;
        div_cnt_d = div_cnt_q + DIV_WIDTH'(1);
        dig_d     = dig_q;
        if (slot_end) begin
            dig_d = (dig_q == LastDig) ? '0 : dig_q + DigW'(1);
        end
        // Holds outputs dark for the first cycle after reset release.
        run_d   = 1'b1;
        value_d = load ? value      : value_q;
        dp_d    = load ? dp_in      : dp_q;
        blank_d = load ? blank_mask : blank_q;
    end

    // A digit is suppressed when it and every more significant nibble are zero.
    always_comb begin
        logic zero_above;
        zero_above = 1'b1;
        suppress   = '0;
        for (int k = NUM_DIGITS - 1; k > 0; k--) begin
            zero_above  = zero_above & (value_q[4*k +: 4] == 4'h0);
            suppress[k] = lz_en & zero_above;
        end
    end

    always_comb begin
        cur_nib   = '0;
        cur_dp    = 1'b0;
        cur_blank = 1'b0;
        cur_sup   = 1'b0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (dig_q == DigW'(k)) begin
                cur_nib   = value_q[4*k +: 4];
                cur_dp    = dp_q[k];
                cur_blank = blank_q[k];
                cur_sup   = suppress[k];
            end
        end
    end

    seg_hex_decode u_hex_decode (
        .nibble_i (cur_nib),
        .seg_o    (cur_glyph)
    );

    // Top four divider bits form the PWM phase; bright 15 keeps the digit lit all slot.
    always_comb begin
        phase        = div_cnt_q[DIV_WIDTH-1 -: 4];
        show         = run_q && (phase <= bright) && !cur_blank && !cur_sup;
        seg_d        = show ? seg_pack(cur_glyph, cur_dp) : SegBlank;
        an_d         = '1;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            an_d[k] = ~(show && (dig_q == DigW'(k)));
        end
        frame_done_d = slot_end && (dig_q == LastDig);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_q    <= '0;
            dig_q        <= '0;
            run_q        <= 1'b0;
            value_q      <= '0;
            dp_q         <= '0;
            blank_q      <= '0;
            seg_q        <= SegBlank;
            an_q         <= '1;
            frame_done_q <= 1'b0;
        end else begin
            div_cnt_q    <= div_cnt_d;
            dig_q        <= dig_d;
            run_q        <= run_d;
            value_q      <= value_d;
            dp_q         <= dp_d;
            blank_q      <= blank_d;
            seg_q        <= seg_d;
            an_q         <= an_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign seg        = seg_q;
    assign an         = an_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver (8 digits, 32-cycle slots): cycle scoreboard
// against a spec-level model plus per-slot vector table and corner sequences.
module tb_seg_scan_driver;

    localparam int NumDigits = 8;
    localparam int DivWidth  = 5;

    logic        clk        = 1'b0;
    logic        rst_n      = 1'b1;
    logic        load       = 1'b0;
    logic [31:0] value      = '0;
    logic [7:0]  dp_in      = '0;
    logic [7:0]  blank_mask = '0;
    logic        lz_en      = 1'b0;
    logic [3:0]  bright     = 4'd15;
    logic [7:0]  seg;
    logic [7:0]  an;
    logic        frame_done;

    int checks = 0;
    int passes = 0;

    seg_scan_driver #(
        .NUM_DIGITS (NumDigits),
        .DIV_WIDTH  (DivWidth)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load),
        .value      (value),
        .dp_in      (dp_in),
        .blank_mask (blank_mask),
        .lz_en      (lz_en),
        .bright     (bright),
        .seg        (seg),
        .an         (an),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s: got %0h, required %0h", name, act, req);
    endtask

    function automatic logic [6:0] ref_dec(input logic [3:0] n);
        case (n)
            4'h0: return 7'b0000001;
            4'h1: return 7'b1001111;
            4'h2: return 7'b0010010;
            4'h3: return 7'b0000110;
            4'h4: return 7'b1001100;
            4'h5: return 7'b0100100;
            4'h6: return 7'b0100000;
            4'h7: return 7'b0001111;
            4'h8: return 7'b0000000;
            4'h9: return 7'b0000100;
            4'hA: return 7'b0001000;
            4'hB: return 7'b1100000;
            4'hC: return 7'b0110001;
            4'hD: return 7'b1000010;
            4'hE: return 7'b0110000;
            default: return 7'b0111000;
        endcase
    endfunction

    typedef struct packed {
        logic [7:0] seg;
        logic [7:0] an;
        logic       fd;
    } exp_t;

    exp_t sb_q[$];

    // Expected output on the n-th counter state after reset release.
    function automatic exp_t model(input int unsigned n, input bit started,
                                   input logic [31:0] v, input logic [7:0] dp,
                                   input logic [7:0] bm, input logic lz,
                                   input logic [3:0] br);
        int unsigned dv, dg;
        logic [3:0]  nib;
        bit          show;
        exp_t        e;
        dv   = n % 32;
        dg   = (n / 32) % 8;
        nib  = v[4*dg +: 4];
        show = started && ((dv / 2) <= 32'(br)) && !bm[dg]
               && !(lz && dg > 0 && (v >> (4*dg)) == 32'd0);
        e.fd  = (n % 256) == 255;
        e.seg = show ? {ref_dec(nib), ~dp[dg]} : 8'hFF;
        e.an  = show ? ~(8'b1 << dg) : 8'hFF;
        return e;
    endfunction

    int unsigned m_t   = 0;
    logic [31:0] m_val = '0;
    logic [7:0]  m_dp  = '0;
    logic [7:0]  m_bl  = '0;

    always @(posedge clk) begin
        exp_t e;
        if (!rst_n) begin
            m_t   = 0;
            m_val = '0;
            m_dp  = '0;
            m_bl  = '0;
            e     = '{seg: 8'hFF, an: 8'hFF, fd: 1'b0};
        end else begin
            m_t++;
            e = model(m_t - 1, m_t >= 2, m_val, m_dp, m_bl, lz_en, bright);
            if (load) begin
                m_val = value;
                m_dp  = dp_in;
                m_bl  = blank_mask;
            end
        end
        sb_q.push_back(e);
        #1;
        e = sb_q.pop_front();
        check($sformatf("scan@%0t", $time), 32'({seg, an, frame_done}), 32'(e));
    end

    typedef struct packed {
        logic [31:0]     value;
        logic [7:0]      dp;
        logic [7:0]      blank;
        logic            lz;
        logic [3:0]      br;
        logic [7:0][7:0] seg;   // per digit, 8'hFF = never lit
        logic [7:0]      lit;   // lit cycles per slot for visible digits
    } vec_t;

    vec_t vecs [6];

    task automatic wait_frame();
        bit found = 1'b0;
        for (int w = 0; w < 300 && !found; w++) begin
            @(posedge clk);
            #1;
            if (frame_done) found = 1'b1;
        end
        check("frame_wait", 32'(found), 32'd1);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] seg_seen, an_seen, exp_an;
        int         lit_n, fd_n, fd_pos;

        vecs[0] = '{value: 32'h89ABCDEF, dp: 8'h00, blank: 8'h00, lz: 1'b0, br: 4'd15,
                    seg: {8'b00000001, 8'b00001001, 8'b00010001, 8'b11000001,
                          8'b01100011, 8'b10000101, 8'b01100001, 8'b01110001},
                    lit: 8'd32};
        vecs[1] = '{value: 32'h00000120, dp: 8'h00, blank: 8'h00, lz: 1'b1, br: 4'd15,
                    seg: {8'hFF, 8'hFF, 8'hFF, 8'hFF,
                          8'hFF, 8'b10011111, 8'b00100101, 8'b00000011},
                    lit: 8'd32};
        vecs[2] = '{value: 32'h76543210, dp: 8'h00, blank: 8'h00, lz: 1'b0, br: 4'd3,
                    seg: {8'b00011111, 8'b01000001, 8'b01001001, 8'b10011001,
                          8'b00001101, 8'b00100101, 8'b10011111, 8'b00000011},
                    lit: 8'd8};
        vecs[3] = '{value: 32'h76543210, dp: 8'h04, blank: 8'h10, lz: 1'b0, br: 4'd15,
                    seg: {8'b00011111, 8'b01000001, 8'b01001001, 8'hFF,
                          8'b00001101, 8'b00100100, 8'b10011111, 8'b00000011},
                    lit: 8'd32};
        vecs[4] = '{value: 32'h00000000, dp: 8'hFF, blank: 8'h00, lz: 1'b1, br: 4'd0,
                    seg: {8'hFF, 8'hFF, 8'hFF, 8'hFF,
                          8'hFF, 8'hFF, 8'hFF, 8'b00000010},
                    lit: 8'd2};
        vecs[5] = '{value: 32'h00F00000, dp: 8'h00, blank: 8'h00, lz: 1'b1, br: 4'd7,
                    seg: {8'hFF, 8'hFF, 8'b01110001, 8'b00000011,
                          8'b00000011, 8'b00000011, 8'b00000011, 8'b00000011},
                    lit: 8'd16};

        // Power-on reset, checked without any clock edge having occurred.
        #1 rst_n = 1'b0;
        #2;
        check("por_seg", 32'(seg), 32'hFF);
        check("por_an", 32'(an), 32'hFF);
        check("por_fd", 32'(frame_done), 32'd0);

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("first_edge_an", 32'(an), 32'hFF);
        @(posedge clk); #1;
        check("second_edge_an", 32'(an), 32'hFE);
        check("second_edge_seg", 32'(seg), 32'h03);

        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            value      = vecs[i].value;
            dp_in      = vecs[i].dp;
            blank_mask = vecs[i].blank;
            lz_en      = vecs[i].lz;
            bright     = vecs[i].br;
            load       = 1'b1;
            @(negedge clk);
            load = 1'b0;
            wait_frame();
            fd_n   = 0;
            fd_pos = -1;
            for (int s = 0; s < 8; s++) begin
                seg_seen = 8'hFF;
                an_seen  = 8'hFF;
                lit_n    = 0;
                for (int c = 0; c < 32; c++) begin
                    @(posedge clk); #1;
                    if (an != 8'hFF) begin
                        lit_n++;
                        an_seen  = an;
                        seg_seen = seg;
                    end
                    if (frame_done) begin
                        fd_n++;
                        fd_pos = s * 32 + c;
                    end
                end
                exp_an = (vecs[i].seg[s] == 8'hFF) ? 8'hFF : ~(8'b1 << s);
                check($sformatf("v%0d_s%0d_seg", i, s), 32'(seg_seen), 32'(vecs[i].seg[s]));
                check($sformatf("v%0d_s%0d_an", i, s), 32'(an_seen), 32'(exp_an));
                check($sformatf("v%0d_s%0d_lit", i, s), 32'(lit_n),
                      (vecs[i].seg[s] == 8'hFF) ? 32'd0 : 32'(vecs[i].lit));
            end
            check($sformatf("v%0d_fd_count", i), 32'(fd_n), 32'd1);
            check($sformatf("v%0d_fd_pos", i), 32'(fd_pos), 32'd255);
        end

        // Back-to-back loads: the last capture wins.
        @(negedge clk);
        dp_in      = 8'h00;
        blank_mask = 8'h00;
        lz_en      = 1'b0;
        bright     = 4'd15;
        value      = 32'h11111111;
        load       = 1'b1;
        @(negedge clk);
        value = 32'h22222222;
        @(negedge clk);
        value = 32'h33333333;
        @(negedge clk);
        load = 1'b0;
        wait_frame();
        @(posedge clk); #1;
        check("last_wins_seg", 32'(seg), 32'b00001101);
        check("last_wins_an", 32'(an), 32'hFE);

        // Reset mid-scan while lit, with a load attempted during reset.
        repeat (45) @(negedge clk);
        check("pre_rst_lit", 32'(an != 8'hFF), 32'd1);
        #2;
        rst_n = 1'b0;
        value = 32'hFFFFFFFF;
        load  = 1'b1;
        #1;
        check("mid_rst_seg", 32'(seg), 32'hFF);
        check("mid_rst_an", 32'(an), 32'hFF);
        check("mid_rst_fd", 32'(frame_done), 32'd0);
        @(negedge clk);
        @(negedge clk);
        load  = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rel_first_an", 32'(an), 32'hFF);
        @(posedge clk); #1;
        check("rel_second_an", 32'(an), 32'hFE);
        check("rel_shadow_clr_seg", 32'(seg), 32'h03);

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/seg_scan_driver.md
SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 8, number of multiplexed digits (legal 1..8).
REQ-002 SHALL have parameter DIV_WIDTH, default 11, slot length = 2^DIV_WIDTH clk cycles per digit (legal 5..24).
REQ-003 SHALL have port clk  input  1  single system clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port load  input  1  one-cycle strobe, captures value/dp_in/blank_mask into shadow registers.
REQ-006 SHALL have port value  input  4*NUM_DIGITS  hex nibbles, digit k = value[4k+3:4k].
REQ-007 SHALL have port dp_in  input  NUM_DIGITS  decimal point per digit, 1 = lit.
REQ-008 SHALL have port blank_mask  input  NUM_DIGITS  1 = digit forced dark.
REQ-009 SHALL have port lz_en  input  1  leading-zero suppression enable, sampled live.
REQ-010 SHALL have port bright  input  4  brightness level, sampled live.
REQ-011 SHALL have port seg  output  8  active-low segments, bit7..bit0 = a,b,c,d,e,f,g,dp.
REQ-012 SHALL have port an  output  NUM_DIGITS  active-low digit selects, one-hot-low or all high.
REQ-013 SHALL have port frame_done  output  1  one-cycle pulse at end of last digit slot.

Function
REQ-014 SHALL run free counter div_cnt (DIV_WIDTH bits) and digit index dig (0..NUM_DIGITS-1); dig increments when div_cnt wraps to 0, wrapping NUM_DIGITS-1 -> 0.
REQ-015 SHALL assert frame_done for exactly the cycle after div_cnt wraps with dig = NUM_DIGITS-1.
REQ-016 SHALL update shadow registers on the clock edge where load = 1; new data visible on seg/an from the following edge; no partial update within a frame beyond that.
REQ-017 SHALL decode nibble to segments (a..g on = 0): 0:0000001, 1:1001111, 2:0010010, 3:0000110, 4:1001100, 5:0100100, 6:0100000, 7:0001111, 8:0000000, 9:0000100, A:0001000, B:1100000, C:0110001, D:1000010, E:0110000, F:0111000; dp bit = ~dp_in[dig].
REQ-018 SHALL define pwm phase = div_cnt[DIV_WIDTH-1:DIV_WIDTH-4]; digit lit iff phase <= bright (bright 0 = 1/16 duty, 15 = full).
REQ-019 SHALL, with lz_en = 1, suppress digit k>0 when all nibbles k..NUM_DIGITS-1 are zero; digit 0 never suppressed; dp of suppressed digit also dark.
REQ-020 SHALL drive an[dig] = 0 only when digit lit, not blank_mask, not suppressed; otherwise an all ones and seg = 8'hFF.
REQ-021 SHALL register seg, an, frame_done; outputs lag internal counter state by one cycle.
REQ-022 SHALL ignore load while rst_n = 0; load every cycle is legal (last capture wins).

Reset
REQ-023 SHALL on rst_n = 0 immediately force seg = 8'hFF, an = all ones, frame_done = 0, div_cnt = 0, dig = 0, shadow registers = 0.
REQ-024 SHALL after rst_n release start at digit 0 slot, first lit output on second rising edge.

Structure
REQ-025 SHALL place segment encoding constants and blank pattern 8'hFF in shared package seg_pkg.
REQ-026 SHALL instantiate combinational sub-module seg_hex_decode (nibble in, 7 segments out).

Verification (NUM_DIGITS=8, DIV_WIDTH=5)
REQ-027 SHALL check: rst_n low mid-scan, no clock -> seg=8'hFF, an=8'hFF, frame_done=0 at once.
REQ-028 SHALL check: load value=32'h89ABCDEF, bright=15 -> slot0 an=8'hFE seg=8'b01110001, slot7 an=8'h7F seg=8'b00000001, each slot 32 cycles, frame_done once per 256 cycles.
REQ-029 SHALL check: lz_en=1, value=32'h00000120 -> an bits 3..7 never low, digit0 seg=8'b00000011.
REQ-030 SHALL check: bright=3 -> an low 8 of 32 cycles per slot (phases 0..3).
REQ-031 SHALL check: dp_in=8'h04, blank_mask=8'h10 -> seg[0]=0 only in slot2, an[4] never low.
